popcount_csa_pipe: RTL and testbench

//  Pipelined, parametrised population counter built only from 3:2 full-adder
//  (carry-save) reduction cells plus a final ripple adder. Each beat's count
//  can also be summed into a running accumulator. Sits between a bit-vector

---
 rtl/popcount_csa_pipe_if.sv | 28 ++
 rtl/popcount_csa_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_popcount_csa_pipe.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/popcount_csa_pipe_if.sv
// Producer/consumer port bundle for popcount_csa_pipe.
// A beat moves on in_valid && in_ready; a result moves on out_valid && out_ready.
interface popcount_csa_pipe_if #(
    parameter int W  = 32,
    parameter int AW = 16
);
    localparam int CW = $clog2(W + 1);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_clear;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_count;
    logic [AW-1:0] out_acc;
    logic          out_sat;

    modport master (
        output in_valid, in_data, in_clear, out_ready,
        input  in_ready, out_valid, out_count, out_acc, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_clear, out_ready,
        output in_ready, out_valid, out_count, out_acc, out_sat
    );
endinterface

// File: rtl/popcount_csa_pipe.sv
// Pipelined population counter: full-adder carry-save tree, LAT-1 carry-save
// pipeline registers, ripple adder, then a saturating accumulator output register.
module popcount_csa_pipe #(
    parameter int W   = 32,
    parameter int LAT = 3,
    parameter int AW  = 16
) (
    input logic                clk,
    input logic                rst,
    popcount_csa_pipe_if.slave bus
);
    localparam int CW = $clog2(W + 1);
    localparam int C  = CW + 1;
    localparam int HB = 16;

    function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    // Column heights of the reduction; carries out of the top column are
    // always zero because the count never reaches 2^CW.
    function automatic int calc_levels();
        int   h  [C];
        int   nh [C];
        int   lv;
        logic busy;
        lv = 0;
        for (int c = 0; c < C; c++) h[c] = 0;
        h[0] = W;
        for (int it = 0; it < W; it++) begin
            busy = 1'b0;
            for (int c = 0; c < C; c++) if (h[c] > 2) busy = 1'b1;
            if (busy) begin
                for (int c = 0; c < C; c++) nh[c] = 0;
                for (int c = 0; c < C; c++) begin
                    nh[c] += h[c] - 2 * (h[c] / 3);
                    if (c + 1 < C) nh[c+1] += h[c] / 3;
                end
                for (int c = 0; c < C; c++) h[c] = nh[c];
                lv++;
            end
        end
        return lv;
    endfunction

    localparam int NL  = calc_levels();
    localparam int HTW = (NL + 1) * C * HB;

    function automatic logic [HTW-1:0] calc_heights();
        logic [HTW-1:0] r;
        int h  [C];
        int nh [C];
        r = '0;
        for (int c = 0; c < C; c++) h[c] = 0;
        h[0] = W;
        for (int l = 0; l <= NL; l++) begin
            for (int c = 0; c < C; c++) r[(l*C+c)*HB +: HB] = HB'(h[c]);
            for (int c = 0; c < C; c++) nh[c] = 0;
            for (int c = 0; c < C; c++) begin
                nh[c] += h[c] - 2 * (h[c] / 3);
                if (c + 1 < C) nh[c+1] += h[c] / 3;
            end
            for (int c = 0; c < C; c++) h[c] = nh[c];
        end
        return r;
    endfunction

    localparam logic [HTW-1:0] HT = calc_heights();

    function automatic int ht(input int l, input int c);
        return int'(HT[(l*C+c)*HB +: HB]);
    endfunction

    logic          advance;
    logic [CW-1:0] csa_r0, csa_r1;
    logic          cur_valid, cur_clear;
    logic [CW-1:0] cur_r0, cur_r1;
    logic [CW-1:0] sum_cnt;
    logic [AW:0]   acc_sum;
    logic          out_valid_q, out_sat_q;
    logic [CW-1:0] out_count_q;
    logic [AW-1:0] out_acc_q;

    assign advance      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = advance;

    // Each level: groups of three bits in a column become one sum in place and
    // one carry in the next column; leftover bits pass straight through.
    always_comb begin : csa_tree
        logic [W-1:0] t [NL+1][C];
        logic [W-1:0] cy;
        logic [1:0]   r;
        int           n, nf, n1, off;
        for (int l = 0; l <= NL; l++)
            for (int c = 0; c < C; c++) t[l][c] = '0;
        cy  = '0;
        r   = '0;
        n   = 0;
        nf  = 0;
        n1  = 0;
        off = 0;
        t[0][0] = bus.in_data;
        for (int l = 0; l < NL; l++) begin
            for (int c = 0; c < C; c++) begin
                n  = ht(l, c);
                nf = n / 3;
                cy = '0;
                for (int f = 0; f < W / 3; f++) begin
                    if (f < nf) begin
                        r = fa(t[l][c][3*f], t[l][c][3*f+1], t[l][c][3*f+2]);
                        t[l+1][c][f] = r[0];
                        cy[f]        = r[1];
                    end
                end
                for (int k = 0; k < W; k++)
                    if (k >= 3 * nf && k < n) t[l+1][c][k-2*nf] = t[l][c][k];
                if (c + 1 < C) begin
                    n1  = ht(l, c + 1);
                    off = n1 - 2 * (n1 / 3);
                    for (int f = 0; f < W / 3; f++)
                        if (f < nf) t[l+1][c+1][off+f] = cy[f];
                end
            end
        end
        csa_r0 = '0;
        csa_r1 = '0;
        for (int c = 0; c < CW; c++) begin
            csa_r0[c] = t[NL][c][0];
            csa_r1[c] = t[NL][c][1];
        end
    end

    generate
        if (LAT == 1) begin : g_nopipe
            assign cur_valid = bus.in_valid;
            assign cur_clear = bus.in_clear;
            assign cur_r0    = csa_r0;
            assign cur_r1    = csa_r1;
        end else begin : g_pipe
            logic [LAT-2:0] v_q, c_q;
            logic [CW-1:0]  r0_q [LAT-1];
            logic [CW-1:0]  r1_q [LAT-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= '0;
                    c_q <= '0;
                    for (int i = 0; i < LAT - 1; i++) begin
                        r0_q[i] <= '0;
                        r1_q[i] <= '0;
                    end
                end else if (advance) begin
                    for (int i = LAT - 2; i > 0; i--) begin
                        v_q[i]  <= v_q[i-1];
                        c_q[i]  <= c_q[i-1];
                        r0_q[i] <= r0_q[i-1];
                        r1_q[i] <= r1_q[i-1];
                    end
                    v_q[0]  <= bus.in_valid;
                    c_q[0]  <= bus.in_clear;
                    r0_q[0] <= csa_r0;
                    r1_q[0] <= csa_r1;
                end
            end

            assign cur_valid = v_q[LAT-2];
            assign cur_clear = c_q[LAT-2];
            assign cur_r0    = r0_q[LAT-2];
            assign cur_r1    = r1_q[LAT-2];
        end
    endgenerate

    always_comb begin : ripple
        logic [1:0] r;
        logic       carry;
        sum_cnt = '0;
        carry   = 1'b0;
        r       = '0;
        for (int i = 0; i < CW; i++) begin
            r          = fa(cur_r0[i], cur_r1[i], carry);
            sum_cnt[i] = r[0];
            carry      = r[1];
        end
    end

    assign acc_sum = (cur_clear ? {(AW+1){1'b0}} : {1'b0, out_acc_q})
                   + {{(AW+1-CW){1'b0}}, sum_cnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_acc_q   <= '0;
            out_sat_q   <= 1'b0;
        end else if (advance) begin
            out_valid_q <= cur_valid;
            if (cur_valid) begin
                out_count_q <= sum_cnt;
                if (acc_sum[AW]) begin
                    out_acc_q <= '1;
                    out_sat_q <= 1'b1;
                end else begin
                    out_acc_q <= acc_sum[AW-1:0];
                    out_sat_q <= cur_clear ? 1'b0 : out_sat_q;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_count = out_count_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_popcount_csa_pipe.sv
// Bench for popcount_csa_pipe: a W=32/LAT=3/AW=8 instance checked against a
// queue-based reference model, plus a W=7/LAT=1 instance for the full sweep.
module tb_popcount_csa_pipe;
  localparam int W_A  = 32;
  localparam int AW_A = 8;
  localparam int CW_A = 6;
  localparam int EW   = 1 + AW_A + CW_A;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  popcount_csa_pipe_if #(.W(W_A), .AW(AW_A)) a_if ();
  popcount_csa_pipe_if #(.W(7), .AW(16)) b_if ();

  popcount_csa_pipe #(.W(W_A), .LAT(3), .AW(AW_A)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  popcount_csa_pipe #(.W(7), .LAT(1), .AW(16)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  int n_vec  = 0;
  int n_fail = 0;
  logic [EW-1:0]   exp_q[$];
  logic [AW_A-1:0] acc_m;
  logic            sat_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: count the ones, then add into an AW_A-bit saturating total.
  task automatic model_push(input logic [W_A-1:0] d, input logic clr);
    int cnt, sum;
    cnt = $countones(d);
    sum = (clr ? 0 : int'(acc_m)) + cnt;
    if (sum > 255) begin
      acc_m = 8'hFF;
      sat_m = 1'b1;
    end else begin
      acc_m = 8'(sum);
      if (clr) sat_m = 1'b0;
    end
    exp_q.push_back({sat_m, acc_m, 6'(cnt)});
  endtask

  task automatic drive_a(input logic v, input logic [W_A-1:0] d, input logic clr, input logic rdy);
    a_if.in_valid  = v;
    a_if.in_data   = d;
    a_if.in_clear  = clr;
    a_if.out_ready = rdy;
  endtask

  // One cycle of dut_a: sample at negedge, score outputs, log accepted beats.
  task automatic tick();
    logic [EW-1:0] e;
    @(negedge clk);
    if (!rst) begin
      if (a_if.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", {63'b0, a_if.out_valid}, 64'd0);
        end else begin
          e = exp_q[0];
          check("out_count", 64'(a_if.out_count), 64'(e[CW_A-1:0]));
          check("out_acc", 64'(a_if.out_acc), 64'(e[CW_A+AW_A-1:CW_A]));
          check("out_sat", 64'(a_if.out_sat), 64'(e[EW-1]));
          if (a_if.out_ready) void'(exp_q.pop_front());
        end
      end
      if (a_if.in_valid && a_if.in_ready) model_push(a_if.in_data, a_if.in_clear);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;
    for (int k = 0; k < 40; k++) if (exp_q.size() != 0) tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int nres;
    rst = 1'b1;
    drive_a(1'b0, '0, 1'b0, 1'b1);
    b_if.in_valid  = 1'b0;
    b_if.in_data   = '0;
    b_if.in_clear  = 1'b0;
    b_if.out_ready = 1'b1;
    acc_m = '0;
    sat_m = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_a_out_valid", 64'(a_if.out_valid), 64'd0);
    check("rst_a_out_count", 64'(a_if.out_count), 64'd0);
    check("rst_a_out_acc", 64'(a_if.out_acc), 64'd0);
    check("rst_a_out_sat", 64'(a_if.out_sat), 64'd0);
    check("rst_b_out_valid", 64'(b_if.out_valid), 64'd0);
    rst = 1'b0;
    check("a_in_ready_idle", 64'(a_if.in_ready), 64'd1);

    // W=7, LAT=1: all 128 vectors back-to-back, one result per cycle
    nres = 0;
    for (int i = 0; i <= 128; i++) begin
      logic [6:0] v;
      logic [6:0] pv;
      v  = 7'(i);
      pv = 7'(i - 1);
      b_if.in_valid = (i < 128);
      b_if.in_data  = v;
      b_if.in_clear = (i == 0);
      @(negedge clk);
      if (b_if.out_valid) nres++;
      check("sweep_out_valid", 64'(b_if.out_valid), 64'(i > 0));
      if (i > 0) check("sweep_out_count", 64'(b_if.out_count), 64'($countones(pv)));
      @(posedge clk);
      #1;
    end
    b_if.in_valid = 1'b0;
    check("sweep_results", 64'(nres), 64'd128);

    // Latency: all-ones with clear appears exactly 3 cycles later
    drive_a(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    tick();
    drive_a(1'b0, '0, 1'b0, 1'b1);
    check("lat_t1_valid", 64'(a_if.out_valid), 64'd0);
    tick();
    check("lat_t2_valid", 64'(a_if.out_valid), 64'd0);
    tick();
    check("lat_t3_valid", 64'(a_if.out_valid), 64'd1);
    check("lat_t3_count", 64'(a_if.out_count), 64'd32);
    check("lat_t3_acc", 64'(a_if.out_acc), 64'd32);
    tick();

    // Back-pressure: fill, then hold out_ready low
    for (int i = 0; i < 8; i++) begin
      drive_a(1'b1, $urandom, ($urandom_range(0, 1) == 0), 1'b0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b1, $urandom, 1'b0, 1'b0);
      check("stall_in_ready", 64'(a_if.in_ready), 64'd0);
      check("stall_out_valid", 64'(a_if.out_valid), 64'd1);
      tick();
    end
    check("stall_held_beats", 64'(exp_q.size()), 64'd3);
    drain();

    // Saturation: 9 all-ones beats, first with clear
    for (int i = 0; i < 9; i++) begin
      drive_a(1'b1, 32'hFFFF_FFFF, (i == 0), 1'b1);
      tick();
    end
    drive_a(1'b0, '0, 1'b0, 1'b1);
    tick();
    tick();
    check("sat_last_valid", 64'(a_if.out_valid), 64'd1);
    check("sat_last_acc", 64'(a_if.out_acc), 64'hFF);
    check("sat_last_sat", 64'(a_if.out_sat), 64'd1);
    drain();

    // Clear after saturation
    drive_a(1'b1, 32'h1, 1'b1, 1'b1);
    tick();
    drive_a(1'b0, '0, 1'b0, 1'b1);
    tick();
    tick();
    check("clr_count", 64'(a_if.out_count), 64'd1);
    check("clr_acc", 64'(a_if.out_acc), 64'd1);
    check("clr_sat", 64'(a_if.out_sat), 64'd0);
    drain();

    // Reset with beats in flight
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, $urandom, 1'b0, 1'b1);
      tick();
    end
    drive_a(1'b0, '0, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    acc_m = '0;
    sat_m = 1'b0;
    check("midrst_out_valid", 64'(a_if.out_valid), 64'd0);
    check("midrst_out_acc", 64'(a_if.out_acc), 64'd0);
    check("midrst_out_sat", 64'(a_if.out_sat), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_idle", 64'(a_if.out_valid), 64'd0);
    end

    // Random traffic with random back-pressure and clears
    for (int i = 0; i < 400; i++) begin
      logic [W_A-1:0] d;
      case ($urandom_range(0, 9))
        0:       d = '0;
        1:       d = '1;
        default: d = $urandom;
      endcase
      drive_a(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) != 0));
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
